// File: rtl/axi_id_order_guard_pkg.sv
// Shared sizing helpers for the AXI per-ID ordering guard.
package axi_id_order_guard_pkg;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_txns);
      return $clog2(max_txns + 1);
   endfunction

endpackage

// File: rtl/axi_id_order_guard_lzc.sv
// Trailing-zero finder: index of the lowest set bit, plus an all-zero flag.
module axi_id_order_guard_lzc
   import axi_id_order_guard_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]                  bits,
   output logic [idx_width(WIDTH)-1:0]       idx,
   output logic                              empty
);

   localparam int unsigned IW = idx_width(WIDTH);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      empty = 1'b1;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx   = IW'(i);
            empty = 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_id_order_guard.sv
// Per-ID ordering guard: stalls requests whose ID is saturated, or that are new while the ID table is full,
// so a downstream ID remapper can never reorder same-ID responses.
module axi_id_order_guard
   import axi_id_order_guard_pkg::*;
#(
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned TABLE_SIZE      = 4,
   parameter int unsigned MAX_TXNS_PER_ID = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                slv_req_valid_i,
   output logic                slv_req_ready_o,
   input  logic [ID_WIDTH-1:0] slv_req_id_i,
   output logic                mst_req_valid_o,
   input  logic                mst_req_ready_i,
   input  logic                mst_rsp_valid_i,
   output logic                mst_rsp_ready_o,
   input  logic [ID_WIDTH-1:0] mst_rsp_id_i,
   input  logic                mst_rsp_last_i,
   output logic                slv_rsp_valid_o,
   input  logic                slv_rsp_ready_i,
   output logic                full_o,
   output logic                err_o
);

   localparam int unsigned CW = cnt_width(MAX_TXNS_PER_ID);
   localparam int unsigned IW = idx_width(TABLE_SIZE);

   typedef struct packed {
      logic                valid;
      logic [ID_WIDTH-1:0] id;
      logic [CW-1:0]       cnt;
   } entry_t;

   entry_t [TABLE_SIZE-1:0] entries_q, entries_d;
   logic   [TABLE_SIZE-1:0] free_vec;
   logic   [IW-1:0]         free_idx, req_idx, rsp_idx;
   logic                    no_free, req_hit, rsp_hit, accept;
   logic                    req_fire, release_fire, err_q, dup_id;

   assign mst_rsp_ready_o = slv_rsp_ready_i;
   assign slv_rsp_valid_o = mst_rsp_valid_i;

   // All lookups use registered state only, so no response-to-request combinational path exists.
   always_comb begin
      req_hit = 1'b0;
      req_idx = '0;
      rsp_hit = 1'b0;
      rsp_idx = '0;
      for (int i = 0; i < int'(TABLE_SIZE); i++) begin
         free_vec[i] = ~entries_q[i].valid;
         if (entries_q[i].valid && (entries_q[i].id == slv_req_id_i)) begin
            req_hit = 1'b1;
            req_idx = IW'(i);
         end
         if (entries_q[i].valid && (entries_q[i].id == mst_rsp_id_i)) begin
            rsp_hit = 1'b1;
            rsp_idx = IW'(i);
         end
      end
   end

   axi_id_order_guard_lzc #(
      .WIDTH (TABLE_SIZE)
   ) u_free_lzc (
      .bits  (free_vec),
      .idx   (free_idx),
      .empty (no_free)
   );

   assign accept          = req_hit ? (entries_q[req_idx].cnt < CW'(MAX_TXNS_PER_ID)) : ~no_free;
   assign mst_req_valid_o = slv_req_valid_i & accept & ~rst_i;
   assign slv_req_ready_o = mst_req_ready_i & accept & ~rst_i;
   assign req_fire        = mst_req_valid_o & mst_req_ready_i;
   assign release_fire    = mst_rsp_valid_i & slv_rsp_ready_i & mst_rsp_last_i;
   assign full_o          = ~|free_vec;
   assign err_o           = err_q;

   // Release is applied before the request so a same-ID pair nets out and the entry stays valid.
   always_comb begin
      entries_d = entries_q;
      if (release_fire && rsp_hit) begin
         entries_d[rsp_idx].cnt = entries_q[rsp_idx].cnt - CW'(1);
         if (entries_q[rsp_idx].cnt == CW'(1)) begin
            entries_d[rsp_idx].valid = 1'b0;
         end
      end
      if (req_fire) begin
         if (req_hit) begin
            entries_d[req_idx].valid = 1'b1;
            entries_d[req_idx].cnt   = entries_d[req_idx].cnt + CW'(1);
         end else begin
            entries_d[free_idx].valid = 1'b1;
            entries_d[free_idx].id    = slv_req_id_i;
            entries_d[free_idx].cnt   = CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         entries_q <= '0;
         err_q     <= 1'b0;
      end else begin
         entries_q <= entries_d;
         err_q     <= release_fire & ~rsp_hit;
      end
   end

   always_comb begin
      dup_id = 1'b0;
      for (int i = 0; i < int'(TABLE_SIZE); i++) begin
         for (int j = i + 1; j < int'(TABLE_SIZE); j++) begin
            if (entries_q[i].valid && entries_q[j].valid && (entries_q[i].id == entries_q[j].id)) begin
               dup_id = 1'b1;
            end
         end
      end
   end

   unique_id_a : assert property (@(posedge clk_i) disable iff (rst_i) !dup_id);

   stable_id_a : assert property (@(posedge clk_i) disable iff (rst_i)
      (slv_req_valid_i && !slv_req_ready_o) |=> $stable(slv_req_id_i));

endmodule
